// File: rtl/spi_slave_rx_pkg.sv
// ============================================================================
// Module      : spi_slave_rx_pkg
// Description : Shared types, constants and SPI mode helper for spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_rx_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int BYTES_W    = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    // Data is sampled on the rising SCK edge when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_rx_if.sv
// ============================================================================
// Module      : spi_slave_rx_if
// Description : SPI pin bundle plus receive-side result signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_slave_rx_if
    import spi_slave_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic                spi_clk_i;
    logic                spi_rx_i;
    logic                spi_en_i;
    logic [DATA_W-1:0]   rx_data_o;
    logic                rx_valid_o;
    logic                rx_busy_o;
    logic                rx_err_o;
    logic                frame_done_o;
    logic [BYTES_W-1:0]  frame_bytes_o;

    modport slave (
        input  spi_clk_i, spi_rx_i, spi_en_i,
        output rx_data_o, rx_valid_o, rx_busy_o, rx_err_o, frame_done_o, frame_bytes_o
    );

    modport master (
        output spi_clk_i, spi_rx_i, spi_en_i,
        input  rx_data_o, rx_valid_o, rx_busy_o, rx_err_o, frame_done_o, frame_bytes_o
    );
endinterface

`default_nettype wire

// File: rtl/spi_slave_rx_sync_edge.sv
// ============================================================================
// Module      : spi_slave_rx_sync_edge
// Description : Two-flop synchroniser plus a third flop for rise/fall detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_rx_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic d_i,
    output logic      q_o,
    output logic      rise_o,
    output logic      fall_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;
endmodule

`default_nettype wire

// File: rtl/spi_slave_rx.sv
// ============================================================================
// Module      : spi_slave_rx
// Description : Oversampling SPI slave receiver; deserialises MOSI into words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter logic CPOL   = 1'b0,
    parameter logic CPHA   = 1'b0,
    parameter int   DATA_W = DEF_DATA_W
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    spi_slave_rx_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(DATA_W - 1);
    localparam logic               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sck_s2, sck_rise, sck_fall;
    logic en_s2, en_rise, en_fall;
    logic mosi_s1_q, mosi_s2_q;

    spi_slave_rx_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.spi_clk_i),
        .q_o    (sck_s2),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_slave_rx_sync_edge #(.RST_VAL(1'b0)) u_sync_en (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.spi_en_i),
        .q_o    (en_s2),
        .rise_o (en_rise),
        .fall_o (en_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= bus.spi_rx_i;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    rx_state_e           state_q;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0]   shreg_q;
    logic [DATA_W-1:0]   data_q;
    logic [BYTES_W-1:0]  bytes_q;
    logic [1:0]          settle_q;
    logic                valid_q, busy_q, err_q, done_q;
    logic                sample_edge, word_end;

    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign word_end    = sample_edge && (cnt_q == c_LAST);
    assign cnt_d       = !sample_edge ? cnt_q :
                         word_end     ? '0    : cnt_q + 1'b1;

    // settle_q masks the artificial en rise produced while the synchroniser
    // refills after reset, so an en held high across reset is not re-entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            bytes_q  <= '0;
            settle_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (en_rise && (settle_q == 2'd3)) begin
                        state_q <= ST_RECV;
                        bytes_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    cnt_q <= cnt_d;
                    if (sample_edge) begin
                        shreg_q <= {shreg_q[DATA_W-3:0], mosi_s2_q};
                    end
                    if (word_end) begin
                        data_q  <= {shreg_q, mosi_s2_q};
                        valid_q <= 1'b1;
                        if (bytes_q != {BYTES_W{1'b1}}) begin
                            bytes_q <= bytes_q + 1'b1;
                        end
                    end
                    // A sample edge in the same cycle is already folded into cnt_d.
                    if (en_fall) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (cnt_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_data_o     = data_q;
    assign bus.rx_valid_o    = valid_q;
    assign bus.rx_busy_o     = busy_q;
    assign bus.rx_err_o      = err_q;
    assign bus.frame_done_o  = done_q;
    assign bus.frame_bytes_o = bytes_q;
endmodule

`default_nettype wire
